// File: rtl/key_pkg.sv
// key_pkg: shared constants and types for the push-button command scheduler.
//   - Key index constants (bit positions in key_in / key_state / command vector).
//   - Debounce FSM state encoding. The MSB of the encoding is the accepted
//     "held" level, so DOWN and REL_CHK both read as pressed.
//   - Default timing constants derived from a 50 MHz clock.
//   - is_onehot(): true when exactly one key is held.
package key_pkg;

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned KEY_ADD  = 0;
  localparam int unsigned KEY_SUB  = 1;
  localparam int unsigned KEY_SHL  = 2;
  localparam int unsigned KEY_SHR  = 3;

  localparam int unsigned CLK_HZ             = 50_000_000;
  localparam int unsigned DEF_CNT_W          = 25;
  localparam int unsigned DEF_DEBOUNCE_CYC   = CLK_HZ / 50;  // 20 ms
  localparam int unsigned DEF_REPEAT_DLY_CYC = CLK_HZ / 2;   // 500 ms
  localparam int unsigned DEF_REPEAT_PER_CYC = CLK_HZ / 10;  // 100 ms

  typedef enum logic [1:0] {
    DB_IDLE      = 2'd0,
    DB_PRESS_CHK = 2'd1,
    DB_DOWN      = 2'd2,
    DB_REL_CHK   = 2'd3
  } deb_state_e;

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchroniser, debounce FSM and stability counter for one key.
//   clk, reset_n  : clock, asynchronous active-low reset
//   key_n_i       : raw active-low button (0 = pressed)
//   level_o       : accepted level, 1 = held
//   press_evt_o   : one-cycle pulse in the cycle a press is accepted
//   rel_evt_o     : one-cycle pulse in the cycle a release is accepted
//   state_o       : debounce FSM state, for observation
// The accept pulses are asserted in the cycle whose closing edge moves the
// FSM into DOWN / IDLE, so downstream registers capture them on the same
// edge that updates level_o.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_n_i,
  output logic       level_o,
  output logic       press_evt_o,
  output logic       rel_evt_o,
  output deb_state_e state_o
);

  localparam logic [CNT_W:0] DEB_LIM = (CNT_W+1)'(DEBOUNCE_CYC);

  logic             sync1_q, sync2_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
  logic [CNT_W:0]   cnt_inc;
  logic             cnt_done, first_done;

  // Counts the current sample too: done when this sample completes the run.
  assign cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign cnt_done   = (cnt_inc >= DEB_LIM);
  assign first_done = (DEB_LIM <= (CNT_W+1)'(1));
  assign cnt_sat    = (cnt_q == '1) ? cnt_q : cnt_inc[CNT_W-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_evt_o = 1'b0;
    rel_evt_o   = 1'b0;
    unique case (state_q)
      DB_IDLE: if (!sync2_q) begin
        if (first_done) begin
          state_d     = DB_DOWN;
          press_evt_o = 1'b1;
        end else begin
          state_d = DB_PRESS_CHK;
          cnt_d   = CNT_W'(1);
        end
      end
      DB_PRESS_CHK: begin
        if (sync2_q) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d     = DB_DOWN;
          cnt_d       = '0;
          press_evt_o = 1'b1;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      DB_DOWN: if (sync2_q) begin
        if (first_done) begin
          state_d   = DB_IDLE;
          rel_evt_o = 1'b1;
        end else begin
          state_d = DB_REL_CHK;
          cnt_d   = CNT_W'(1);
        end
      end
      DB_REL_CHK: begin
        if (!sync2_q) begin
          state_d = DB_DOWN;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d   = DB_IDLE;
          cnt_d     = '0;
          rel_evt_o = 1'b1;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = (state_q == DB_DOWN) || (state_q == DB_REL_CHK);
  assign state_o = state_q;

endmodule

// File: rtl/key_cmd_sched.sv
// key_cmd_sched: turns four bouncing active-low buttons into single-cycle
// commands for the LED add/sub/shift register.
//   clk, reset_n : 50 MHz clock, asynchronous active-low reset
//   key_in[3:0]  : raw buttons, 0 = pressed (add, sub, shl, shr)
//   cmd_add/sub/shl/shr : registered one-cycle command pulses, at most one per cycle
//   key_state[3:0] : debounced level, 1 = held
// Accepted presses and auto-repeat ticks set bits in a pending register; a
// fixed-priority arbiter (lowest index first) issues one pending bit per cycle.
// A set that lands on a bit being issued in the same cycle merges into that
// issue, so a pend bit never yields back-to-back pulses.
// Handshake: none; every output is a free-running level or one-cycle pulse.
module key_cmd_sched
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter bit          REPEAT_EN      = 1'b1,
  parameter int unsigned REPEAT_DLY_CYC = DEF_REPEAT_DLY_CYC,
  parameter int unsigned REPEAT_PER_CYC = DEF_REPEAT_PER_CYC
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic                cmd_add,
  output logic                cmd_sub,
  output logic                cmd_shl,
  output logic                cmd_shr,
  output logic [NUM_KEYS-1:0] key_state
);

  localparam logic [63:0] CNT_MAX   = (64'd1 << CNT_W) - 64'd1;
  localparam bit          PARAMS_OK = (DEBOUNCE_CYC >= 1) &&
                                      (64'(DEBOUNCE_CYC)   <= CNT_MAX) &&
                                      (64'(REPEAT_DLY_CYC) <= CNT_MAX) &&
                                      (64'(REPEAT_PER_CYC) <= CNT_MAX);

  logic [NUM_KEYS-1:0] level, press_evt, rel_evt, rpt_tick;
  logic [NUM_KEYS-1:0] pend_q, pend_d, grant, cmd_q, cmd_d;
  deb_state_e          deb_state [NUM_KEYS];

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_deb (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_n_i    (key_in[gi]),
      .level_o    (level[gi]),
      .press_evt_o(press_evt[gi]),
      .rel_evt_o  (rel_evt[gi]),
      .state_o    (deb_state[gi])
    );

    a_level_matches_state: assert property (@(posedge clk) disable iff (!reset_n)
      level[gi] == ((deb_state[gi] == DB_DOWN) || (deb_state[gi] == DB_REL_CHK)));
  end

  assign key_state = level;

  // Repeat timer: restarts on every accepted change; runs only with exactly
  // one key held. Delay phase first, then the shorter period phase.
  if (REPEAT_EN) begin : g_rpt
    localparam logic [CNT_W:0] DLY_LIM = (CNT_W+1)'(REPEAT_DLY_CYC);
    localparam logic [CNT_W:0] PER_LIM = (CNT_W+1)'(REPEAT_PER_CYC);

    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [CNT_W:0]   tmr_inc;
    logic             per_q, per_d, fire;

    assign tmr_inc = {1'b0, tmr_q} + (CNT_W+1)'(1);

    always_comb begin
      tmr_d = (tmr_q == '1) ? tmr_q : tmr_inc[CNT_W-1:0];
      per_d = per_q;
      fire  = 1'b0;
      // A tick coinciding with an accepted change is dropped: the key set
      // it belonged to is no longer current.
      if (((press_evt | rel_evt) != '0) || !is_onehot(level)) begin
        tmr_d = '0;
        per_d = 1'b0;
      end else if (tmr_inc >= (per_q ? PER_LIM : DLY_LIM)) begin
        tmr_d = '0;
        per_d = 1'b1;
        fire  = 1'b1;
      end
    end

    assign rpt_tick = fire ? level : '0;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        tmr_q <= '0;
        per_q <= 1'b0;
      end else begin
        tmr_q <= tmr_d;
        per_q <= per_d;
      end
    end
  end else begin : g_no_rpt
    assign rpt_tick = '0;
  end

  // Lowest set bit of pend_q wins (add > sub > shl > shr).
  assign grant  = pend_q & (~pend_q + NUM_KEYS'(1));
  assign pend_d = (pend_q | press_evt | rpt_tick) & ~grant;
  assign cmd_d  = grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      cmd_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cmd_q  <= cmd_d;
    end
  end

  assign cmd_add = cmd_q[KEY_ADD];
  assign cmd_sub = cmd_q[KEY_SUB];
  assign cmd_shl = cmd_q[KEY_SHL];
  assign cmd_shr = cmd_q[KEY_SHR];

  a_params_fit: assert property (@(posedge clk) PARAMS_OK);
  a_cmd_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(cmd_q));

endmodule

// File: tb/tb_key_cmd_sched.sv
module tb_key_cmd_sched;

  localparam int D   = 4;
  localparam int DLY = 20;
  localparam int PER = 8;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset_n;
  logic [3:0] key_in;
  logic       cmd_add, cmd_sub, cmd_shl, cmd_shr;
  logic [3:0] key_state;

  int cyc;
  int n_cmp;
  int n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  key_cmd_sched #(
    .DEBOUNCE_CYC  (D),
    .CNT_W         (8),
    .REPEAT_EN     (1'b1),
    .REPEAT_DLY_CYC(DLY),
    .REPEAT_PER_CYC(PER)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .key_in   (key_in),
    .cmd_add  (cmd_add),
    .cmd_sub  (cmd_sub),
    .cmd_shl  (cmd_shl),
    .cmd_shr  (cmd_shr),
    .key_state(key_state)
  );

  // ---------------- checking helpers ----------------
  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_vec(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got cmd=%b keys=%b expected cmd=%b keys=%b (cycle %0d)",
               name, act[7:4], act[3:0], exp[7:4], exp[3:0], cyc);
    end
  endtask

  // Pulse log: cycle and key of every observed command pulse.
  int pulse_cyc[$];
  int pulse_key[$];

  function automatic int first_after(input int k, input int c);
    int best;
    best = -1;
    for (int i = 0; i < pulse_cyc.size(); i++)
      if (pulse_key[i] == k && pulse_cyc[i] >= c && (best < 0 || pulse_cyc[i] < best))
        best = pulse_cyc[i];
    return best;
  endfunction

  function automatic int count_between(input int k, input int a, input int b);
    int n;
    n = 0;
    for (int i = 0; i < pulse_cyc.size(); i++)
      if (pulse_key[i] == k && pulse_cyc[i] >= a && pulse_cyc[i] <= b) n++;
    return n;
  endfunction

  function automatic bit one_key_held(input logic [3:0] v);
    return $countones(v) == 1;
  endfunction

  // ---------------- behavioural model ----------------
  // A key's accepted level flips once the last D synchronised samples all
  // disagree with it; a synchronised sample is the raw input two edges back.
  // With exactly one key held, repeats land DLY edges after the last change
  // and every PER edges after that.
  logic [3:0] m_hist[$];
  logic [3:0] m_level, m_pend, m_new, m_set, m_grant;
  int         m_edge, m_t0, m_k;
  bit         m_all, m_chg;
  logic [7:0] exp_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hist.delete();
      for (int j = 0; j < D + 2; j++) m_hist.push_back(4'hF);
      m_level = '0;
      m_pend  = '0;
      m_edge  = 0;
      m_t0    = 0;
    end else begin
      m_edge++;
      m_hist.push_back(key_in);
      void'(m_hist.pop_front());
      m_new = m_level;
      for (int i = 0; i < 4; i++) begin
        m_all = 1'b1;
        for (int j = 0; j < D; j++)
          if (m_hist[j][i] != m_level[i]) m_all = 1'b0;
        if (m_all) m_new[i] = ~m_level[i];
      end
      m_chg = (m_new != m_level);
      m_set = m_new & ~m_level;
      if (!m_chg && one_key_held(m_level)) begin
        m_k = m_edge - m_t0;
        if (m_k >= DLY && ((m_k - DLY) % PER) == 0) m_set = m_set | m_level;
      end
      if (m_chg) m_t0 = m_edge;
      m_grant = '0;
      for (int i = 0; i < 4; i++)
        if (m_pend[i] && m_grant == '0) m_grant[i] = 1'b1;
      m_pend  = (m_pend | m_set) & ~m_grant;
      m_level = m_new;
      exp_q.push_back({m_grant, m_new});
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [7:0] dut_vec, exp_v;

  always @(negedge clk) begin
    dut_vec = {cmd_shr, cmd_shl, cmd_sub, cmd_add, key_state};
    if (!reset_n) begin
      exp_q.delete();
      check_vec("outputs_in_reset", dut_vec, 8'h00);
    end else if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check_vec("cycle_model", dut_vec, exp_v);
      for (int k = 0; k < 4; k++)
        if (dut_vec[4+k]) begin
          pulse_cyc.push_back(cyc);
          pulse_key.push_back(k);
        end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int f, r, segs;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    cyc     = 0;
    key_in  = 4'hF;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_int("reset_key_state", int'(key_state), 0);
    check_int("reset_cmds", int'({cmd_shr, cmd_shl, cmd_sub, cmd_add}), 0);
    reset_n = 1'b1;
    tick(5);

    // 1: clean press of add, held 10 cycles
    key_in[0] = 1'b0; f = cyc;
    tick(10);
    key_in[0] = 1'b1;
    tick(15);
    check_int("s1_add_count", count_between(0, f, cyc), 1);
    check_int("s1_add_latency", first_after(0, f) - f, 7);

    // 2: bounce on sub, then a proper hold
    key_in[1] = 1'b0; f = cyc;
    tick(3); key_in[1] = 1'b1;
    tick(1); key_in[1] = 1'b0;
    tick(2); key_in[1] = 1'b1;
    tick(12);
    check_int("s2_bounce_no_sub", count_between(1, f, cyc), 0);
    key_in[1] = 1'b0; f = cyc;
    tick(6); key_in[1] = 1'b1;
    tick(12);
    check_int("s2_sub_count", count_between(1, f, cyc), 1);
    check_int("s2_sub_latency", first_after(1, f) - f, 7);

    // 3: all four keys in the same cycle
    key_in = 4'h0; f = cyc;
    tick(12);
    key_in = 4'hF;
    tick(15);
    check_int("s3_add_at", first_after(0, f) - f, 7);
    check_int("s3_sub_at", first_after(1, f) - f, 8);
    check_int("s3_shl_at", first_after(2, f) - f, 9);
    check_int("s3_shr_at", first_after(3, f) - f, 10);

    // 4: hold shl 60 cycles for auto-repeat
    key_in[2] = 1'b0; f = cyc;
    tick(60);
    key_in[2] = 1'b1;
    tick(20);
    check_int("s4_shl_count", count_between(2, f, cyc), 6);
    check_int("s4_first", first_after(2, f) - f, 7);
    check_int("s4_first_repeat", first_after(2, f + 8) - f, 27);
    check_int("s4_last_repeat", first_after(2, f + 52) - f, 59);
    check_int("s4_none_after_release", first_after(2, f + 60), -1);

    // 5: shr repeating, add pressed and released
    key_in[3] = 1'b0; f = cyc;
    tick(30); key_in[0] = 1'b0;
    tick(10); key_in[0] = 1'b1;
    tick(40); key_in[3] = 1'b1;
    tick(20);
    check_int("s5_add_count", count_between(0, f, cyc), 1);
    check_int("s5_add_at", first_after(0, f) - f, 37);
    check_int("s5_shr_resume", first_after(3, f + 36) - f, 67);
    check_int("s5_shr_count", count_between(3, f, cyc), 6);

    // 6: reset in the middle of a held shl
    key_in[2] = 1'b0; f = cyc;
    tick(30);
    reset_n = 1'b0;
    #1;
    check_int("s6_reset_key_state", int'(key_state), 0);
    tick(2);
    reset_n = 1'b1; r = cyc;
    tick(20);
    key_in[2] = 1'b1;
    tick(20);
    check_int("s6_first_after_reset", first_after(2, f + 28) - r, 7);

    // randomized traffic, checked cycle by cycle against the model
    segs = 60;
    for (int s = 0; s < segs; s++) begin
      key_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
      else tick($urandom_range(4, 40));
    end
    key_in = 4'hF;
    tick(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
